// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes/InvSubBytes engine: buffers one 128-bit state and substitutes
// LANES bytes per clock (most-significant group first) through shared S-box lanes.
module sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [127:0] i_data,
   input  logic         i_inverse,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [127:0] o_data,
   output logic         o_busy
);

   localparam int CYCLES = 16 / LANES;
   localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SUB  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   // Entry 0x00 sits in the top byte of each table.
   localparam logic [2047:0] FWD_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_TAB = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
      return FWD_TAB[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_TAB[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   logic [1:0]    state_q;
   logic [127:0]  buf_q;
   logic          mode_q;
   logic [CW-1:0] cnt_q;

   logic [127:0]  sub_buf;
   logic [3:0]    base;
   logic [3:0]    idx;
   logic [6:0]    off;
   logic [7:0]    in_byte;

   // Group cnt covers bytes base .. base+LANES-1, where base counts down from the top.
   always_comb begin
      sub_buf = buf_q;
      base    = 4'((CYCLES - 1 - int'(cnt_q)) * LANES);
      idx     = '0;
      off     = '0;
      in_byte = '0;
      for (int l = 0; l < LANES; l++) begin
         idx     = base + 4'(l);
         off     = {idx, 3'b000};
         in_byte = buf_q[off +: 8];
         sub_buf[off +: 8] = mode_q ? inv_sbox(in_byte) : fwd_sbox(in_byte);
      end
   end

   // Both sides use valid/ready: a transfer happens on an edge where valid and ready
   // are both high; a producer holds valid and data steady until that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  buf_q   <= i_data;
                  mode_q  <= i_inverse;
                  cnt_q   <= '0;
                  state_q <= SUB;
               end
            end
            SUB: begin
               buf_q <= sub_buf;
               if (cnt_q == CW'(CYCLES - 1)) begin
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (i_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == DONE);
   assign o_busy  = (state_q != IDLE);
   assign o_data  = buf_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: five instances (LANES = 1, 2, 4, 8, 16) checked
// against hand-computed FIPS-197 S-box results, latency and handshake behaviour.
module tb_sub_bytes_iter;

   localparam logic [127:0] VEC_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] VEC_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] VEC_ONE = 128'hd43de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] ALL_00  = 128'h0;
   localparam logic [127:0] ALL_63  = {16{8'h63}};
   localparam logic [127:0] ALL_53  = {16{8'h53}};
   localparam logic [127:0] ALL_ED  = {16{8'hed}};

   logic         clk;
   logic         rst;
   logic         iv    [5];
   logic         ordy  [5];
   logic [127:0] id    [5];
   logic         iinv  [5];
   logic         ov    [5];
   logic         ir    [5];
   logic [127:0] od    [5];
   logic         obusy [5];

   int errors;
   int checks;
   logic [127:0] exp_q[$];

   for (genvar k = 0; k < 5; k++) begin : g_dut
      sub_bytes_iter #(.LANES(1 << k)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .i_valid  (iv[k]),
         .o_ready  (ordy[k]),
         .i_data   (id[k]),
         .i_inverse(iinv[k]),
         .o_valid  (ov[k]),
         .i_ready  (ir[k]),
         .o_data   (od[k]),
         .o_busy   (obusy[k])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (ordy[k] !== 1'b1 || ov[k] !== 1'b0 || obusy[k] !== 1'b0 || od[k] !== 128'h0) begin
            errors++;
            $display("FAIL reset_state lanes=%0d: ready=%b valid=%b busy=%b data=%h, want 1 0 0 0",
                     1 << k, ordy[k], ov[k], obusy[k], od[k]);
         end
      end
   endtask

   // One state through instance k; checks ready low during work, latency and result.
   task automatic run_vec(input int k, input logic [127:0] din, input logic inv,
                          input logic [127:0] exp_d, input string name);
      int lat;
      int exp_lat;
      exp_lat = 16 >> k;
      checks++;
      if (ordy[k] !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready_idle lanes=%0d: got %b want 1", name, 1 << k, ordy[k]);
      end
      iv[k] = 1'b1; id[k] = din; iinv[k] = inv; ir[k] = 1'b0;
      tick;
      iv[k] = 1'b0; id[k] = ~din; iinv[k] = ~inv;
      lat = 0;
      while (ov[k] !== 1'b1 && lat < 40) begin
         checks++;
         if (ordy[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_busy lanes=%0d: got %b want 0", name, 1 << k, ordy[k]);
         end
         tick;
         lat++;
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s_latency lanes=%0d: got %0d want %0d", name, 1 << k, lat, exp_lat);
      end
      checks++;
      if (od[k] !== exp_d) begin
         errors++;
         $display("FAIL %s_data lanes=%0d: got %h want %h", name, 1 << k, od[k], exp_d);
      end
      ir[k] = 1'b1;
      tick;
      ir[k] = 1'b0;
      checks++;
      if (ov[k] !== 1'b0 || ordy[k] !== 1'b1) begin
         errors++;
         $display("FAIL %s_release lanes=%0d: valid=%b ready=%b want 0 1", name, 1 << k, ov[k], ordy[k]);
      end
   endtask

   task automatic test_forward;
      run_vec(2, VEC_IN, 1'b0, VEC_OUT, "fwd_vec");
   endtask

   task automatic test_inverse;
      run_vec(2, VEC_OUT, 1'b1, VEC_IN, "inv_vec");
      run_vec(2, ALL_00, 1'b0, ALL_63, "fwd_zero");
      run_vec(2, ALL_63, 1'b1, ALL_00, "inv_63");
   endtask

   task automatic test_backpressure;
      int n;
      iv[2] = 1'b1; id[2] = ALL_53; iinv[2] = 1'b0; ir[2] = 1'b0;
      tick;
      iv[2] = 1'b0;
      n = 0;
      while (ov[2] !== 1'b1 && n < 40) begin
         tick;
         n++;
      end
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (ov[2] !== 1'b1 || od[2] !== ALL_ED || ordy[2] !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold cycle=%0d: valid=%b ready=%b data=%h want 1 0 %h",
                     c, ov[2], ordy[2], od[2], ALL_ED);
         end
         tick;
      end
      ir[2] = 1'b1;
      tick;
      ir[2] = 1'b0;
      checks++;
      if (ordy[2] !== 1'b1 || ov[2] !== 1'b0 || obusy[2] !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_release: ready=%b valid=%b busy=%b want 1 0 0", ordy[2], ov[2], obusy[2]);
      end
   endtask

   task automatic test_lane_sweep;
      for (int k = 0; k < 5; k++) begin
         run_vec(k, VEC_IN, 1'b0, VEC_OUT, "sweep");
      end
   endtask

   task automatic test_first_group;
      int n;
      iv[0] = 1'b1; id[0] = VEC_IN; iinv[0] = 1'b0; ir[0] = 1'b0;
      tick;
      iv[0] = 1'b0;
      checks++;
      if (od[0] !== VEC_IN) begin
         errors++;
         $display("FAIL first_group_loaded: got %h want %h", od[0], VEC_IN);
      end
      tick;
      checks++;
      if (od[0] !== VEC_ONE) begin
         errors++;
         $display("FAIL first_group_msb: got %h want %h", od[0], VEC_ONE);
      end
      n = 0;
      while (ov[0] !== 1'b1 && n < 40) begin
         tick;
         n++;
      end
      checks++;
      if (od[0] !== VEC_OUT) begin
         errors++;
         $display("FAIL first_group_final: got %h want %h", od[0], VEC_OUT);
      end
      ir[0] = 1'b1;
      tick;
      ir[0] = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic seen;
      iv[0] = 1'b1; id[0] = VEC_IN; iinv[0] = 1'b0; ir[0] = 1'b1;
      tick;
      iv[0] = 1'b0;
      tick;
      tick;
      checks++;
      if (obusy[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_busy: got %b want 1", obusy[0]);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++;
      if (obusy[0] !== 1'b0 || ov[0] !== 1'b0 || od[0] !== 128'h0 || ordy[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_state: busy=%b valid=%b data=%h ready=%b want 0 0 0 1",
                  obusy[0], ov[0], od[0], ordy[0]);
      end
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (ov[0] !== 1'b0) seen = 1'b1;
         tick;
      end
      ir[0] = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_spurious: valid seen=%b want 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      int sent;
      int got;
      int acc_cyc[2];
      logic acc;
      logic [127:0] exp_d;
      exp_q = {};
      cyc = 0; sent = 0; got = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      iv[2] = 1'b1; id[2] = VEC_IN; iinv[2] = 1'b0; ir[2] = 1'b1;
      while (got < 2 && cyc < 60) begin
         if (ov[2] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_unexpected_output: got %h with nothing expected", od[2]);
            end else begin
               exp_d = exp_q.pop_front();
               if (od[2] !== exp_d) begin
                  errors++;
                  $display("FAIL b2b_data result=%0d: got %h want %h", got, od[2], exp_d);
               end
            end
            got++;
            checks++;
            if (ordy[2] !== 1'b0) begin
               errors++;
               $display("FAIL b2b_no_accept_in_done: ready=%b want 0", ordy[2]);
            end
         end
         acc = (iv[2] === 1'b1 && ordy[2] === 1'b1);
         if (acc) begin
            exp_q.push_back((sent == 0) ? VEC_OUT : ALL_ED);
            acc_cyc[sent] = cyc;
         end
         tick;
         cyc++;
         if (acc) begin
            sent++;
            if (sent == 1) id[2] = ALL_53;
            else iv[2] = 1'b0;
         end
      end
      iv[2] = 1'b0;
      ir[2] = 1'b0;
      checks++;
      if (got != 2 || sent != 2) begin
         errors++;
         $display("FAIL b2b_count: accepted=%0d results=%0d want 2 2", sent, got);
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 6) begin
         errors++;
         $display("FAIL b2b_interval: got %0d want 6", acc_cyc[1] - acc_cyc[0]);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         iv[k] = 1'b0; id[k] = '0; iinv[k] = 1'b0; ir[k] = 1'b0;
      end
      test_reset;
      test_forward;
      test_inverse;
      test_backpressure;
      test_lane_sweep;
      test_first_group;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
Iterative, parametrised AES SubBytes/InvSubBytes engine for the 128-bit state. It substitutes LANES bytes per clock through LANES shared forward/inverse S-box lookup pairs, trading latency for area. It sits between the round-key adder and ShiftRows in the round datapath. It uses a valid/ready handshake on both sides and buffers one full 128-bit state.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
CYCLES, 16/LANES, derived localparam; number of substitution cycles per state.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
i_valid  input  1  upstream presents a state.
o_ready  output  1  engine can accept a state.
i_data  input  128  state in; byte 15 = [127:120] … byte 0 = [7:0].
i_inverse  input  1  0 = forward S-box, 1 = inverse S-box; sampled only at accept.
o_valid  output  1  substituted state available.
i_ready  input  1  downstream accepts the output.
o_data  output  128  substituted state, same byte order.
o_busy  output  1  high in SUB or DONE.

Behaviour:
- FSM states: IDLE, SUB, DONE. Internal registers: 128-bit buf, mode bit, group counter cnt (width clog2(CYCLES), minimum 1).
- Reset (rst=1 at an edge): state=IDLE, buf=0, mode=0, cnt=0. Outputs after reset: o_ready=1, o_valid=0, o_busy=0, o_data=0. Reset mid-operation discards the in-flight state with no output.
- o_ready = (state==IDLE). o_valid = (state==DONE). o_busy = (state!=IDLE). o_data = buf at all times.
- IDLE: on i_valid && o_ready, buf<=i_data, mode<=i_inverse, cnt<=0, go to SUB. Otherwise hold.
- SUB: each cycle, replace bytes [16-LANES*(cnt+1) .. 15-LANES*cnt] of buf, i.e. MSB group first, with S(byte) if mode=0, else S^-1(byte). Other bytes hold. If cnt==CYCLES-1, go to DONE and hold cnt; else cnt<=cnt+1. Inputs are ignored in SUB.
- DONE: hold buf. When i_ready=1, go to IDLE. o_valid must stay high and o_data stable until accepted.
- No new state is accepted in DONE, even when i_ready is high the same cycle. Acceptance resumes the cycle after the return to IDLE.
- Latency: accept at edge E; o_valid rises after edge E+CYCLES (LANES=16: 1 cycle; LANES=1: 16 cycles). Minimum initiation interval is CYCLES+2 clocks with i_ready tied high.
- S-box tables: the full FIPS-197 forward and inverse 256-entry tables, combinational per lane, indexed by the unsigned byte value. No registered lookup.
- Changes to i_inverse or i_data after accept have no effect.

Test Plan:
1. Reset, then LANES=4, i_inverse=0, i_data=0x193de3bea0f4e22b9ac68d2ae9f84808 -> o_data=0xd42711aee0bf98f1b8b45de51e415230, o_valid high exactly 4 cycles after accept; o_ready=0 throughout.
2. Same vector with i_inverse=1 on the output value -> o_data=0x193de3bea0f4e22b9ac68d2ae9f84808. Also all-0x00 forward -> all-0x63, and all-0x63 inverse -> all-0x00.
3. Backpressure: i_ready=0 for 10 cycles after o_valid -> o_valid and o_data (bytes all 0xED from input all-0x53) stay stable; i_ready=1 -> IDLE next cycle, o_ready=1.
4. Parameter sweep LANES=1,2,8,16 with vector from test 1 -> identical o_data; latency 16, 8, 2, 1 cycles respectively; intermediate buf after first SUB cycle with LANES=1 has only byte 15 replaced (0xd4).
5. Assert rst during SUB (cnt=2, LANES=1) -> next cycle o_busy=0, o_valid=0, o_data=0, o_ready=1; no spurious o_valid follows.
6. i_valid held high with a second state while in SUB/DONE -> second state not taken until after output handshake; both results correct and in order.
